trng_collector: RTL and testbench

- Consumer side of the ring-oscillator TRNG: drives the oscillator enable and samples the raw asynchronous `trng_out` bit.
- Synchronises the bit, applies a von Neumann debiaser and a repetition-count health test, and packs debiased bits into words.
- Presents words to the SoC bus/CSR logic over a valid/ready interface.
- Sits between a trng_NxM configuration wrapper and the peripheral register block.

---
 rtl/trng_pkg.sv | 22 ++
 rtl/trng_debias.sv | 53 +++++
 rtl/trng_collector.sv | 182 ++++++++++++++++++
 tb/tb_trng_collector.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/trng_pkg.sv
// rtl/trng_pkg.sv - shared state type and width helpers for the TRNG collector
package trng_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WARMUP  = 3'd1,
    ST_COLLECT = 3'd2,
    ST_FULL    = 3'd3,
    ST_FAIL    = 3'd4
  } trng_coll_state_t;

  // Bit counter must hold WORD_WIDTH itself (the "word complete" value).
  function automatic int unsigned bitcnt_w(input int unsigned word_width);
    return $clog2(word_width + 1);
  endfunction

  // Repetition counter must hold REP_LIMIT itself (the trip value).
  function automatic int unsigned repcnt_w(input int unsigned rep_limit);
    return $clog2(rep_limit + 1);
  endfunction

endpackage

// File: rtl/trng_debias.sv
// rtl/trng_debias.sv - oscillator bit synchroniser and von Neumann pairing
module trng_debias (
  input  logic clk,
  input  logic rst_n,
  input  logic trng_in,
  input  logic clear_i,
  output logic raw_o,
  output logic bit_valid_o,
  output logic bit_o
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic phase_q, phase_d;
  logic a_q, a_d;

  assign raw_o = sync2_q;
  assign bit_o = a_q;

  // Pairing: phase 0 latches sample a, phase 1 emits a when b differs.
  // clear_i parks the pairing at phase 0 so a fresh run starts aligned.
  always_comb begin
    sync1_d     = trng_in;
    sync2_d     = sync1_q;
    phase_d     = 1'b0;
    a_d         = a_q;
    bit_valid_o = 1'b0;
    if (!clear_i) begin
      phase_d = ~phase_q;
      if (!phase_q) begin
        a_d = sync2_q;
      end else begin
        bit_valid_o = (sync2_q != a_q);
      end
    end
  end

  // Synchroniser and pairing state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      phase_q <= 1'b0;
      a_q     <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      phase_q <= phase_d;
      a_q     <= a_d;
    end
  end

endmodule

// File: rtl/trng_collector.sv
// rtl/trng_collector.sv - TRNG consumer: warm-up, health test, word packing, valid/ready output
module trng_collector
  import trng_pkg::*;
#(
  parameter int unsigned WORD_WIDTH    = 32,
  parameter int unsigned WARMUP_CYCLES = 64,
  parameter int unsigned REP_LIMIT     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable_i,
  input  logic                  trng_in,
  output logic                  trng_en_o,
  output logic [WORD_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  health_fail_o,
  input  logic                  clear_fail_i
);

  localparam int unsigned CNT_W = bitcnt_w(WORD_WIDTH);
  localparam int unsigned REP_W = repcnt_w(REP_LIMIT);
  localparam int unsigned WU_W  = $clog2(WARMUP_CYCLES);

  trng_coll_state_t state_q, state_d;
  logic                  en_q, en_d;
  logic [WORD_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  fail_q, fail_d;
  logic [WORD_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [REP_W-1:0]      rep_q, rep_d;
  logic                  prev_q, prev_d;
  logic [WU_W-1:0]       wcnt_q, wcnt_d;

  logic                  raw;
  logic                  deb_valid;
  logic                  deb_bit;
  logic                  hs;
  logic [REP_W-1:0]      rep_next;
  logic [WORD_WIDTH-1:0] shift_next;
  logic [CNT_W-1:0]      cnt_next;

  trng_debias u_debias (
    .clk         (clk),
    .rst_n       (rst_n),
    .trng_in     (trng_in),
    .clear_i     (state_q != ST_COLLECT),
    .raw_o       (raw),
    .bit_valid_o (deb_valid),
    .bit_o       (deb_bit)
  );

  assign trng_en_o     = en_q;
  assign data_o        = data_q;
  assign valid_o       = valid_q;
  assign health_fail_o = fail_q;

  // Next-state logic: health failure outranks disable, which outranks packing/handshake.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    valid_d    = valid_q;
    fail_d     = fail_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    rep_d      = rep_q;
    wcnt_d     = wcnt_q;
    prev_d     = raw;
    hs         = valid_q && ready_i;
    shift_next = {shift_q[WORD_WIDTH-2:0], deb_bit};
    cnt_next   = cnt_q + CNT_W'(1);
    if (raw != prev_q) begin
      rep_next = REP_W'(1);
    end else if (rep_q == REP_W'(REP_LIMIT)) begin
      rep_next = rep_q;
    end else begin
      rep_next = rep_q + REP_W'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (enable_i) begin
          state_d = ST_WARMUP;
          wcnt_d  = WU_W'(WARMUP_CYCLES - 1);
        end
      end
      ST_WARMUP: begin
        if (!enable_i) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          shift_d = '0;
          cnt_d   = '0;
        end else if (wcnt_q == '0) begin
          state_d = ST_COLLECT;
          cnt_d   = '0;
          rep_d   = '0;
        end else begin
          wcnt_d = wcnt_q - WU_W'(1);
        end
      end
      ST_COLLECT, ST_FULL: begin
        rep_d = rep_next;
        if (rep_next == REP_W'(REP_LIMIT)) begin
          state_d = ST_FAIL;
          fail_d  = 1'b1;
          valid_d = 1'b0;
          shift_d = '0;
          cnt_d   = '0;
        end else if (!enable_i) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          shift_d = '0;
          cnt_d   = '0;
        end else begin
          if (hs) begin
            valid_d = 1'b0;
          end
          if (state_q == ST_COLLECT) begin
            if (deb_valid) begin
              shift_d = shift_next;
              cnt_d   = cnt_next;
              if (cnt_next == CNT_W'(WORD_WIDTH)) begin
                if (!valid_q || hs) begin
                  data_d  = shift_next;
                  valid_d = 1'b1;
                  cnt_d   = '0;
                end else begin
                  state_d = ST_FULL;
                end
              end
            end
          end else if (hs) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            cnt_d   = '0;
            state_d = ST_COLLECT;
          end
        end
      end
      ST_FAIL: begin
        if (clear_fail_i) begin
          state_d = ST_IDLE;
          fail_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    en_d = (state_d == ST_WARMUP) || (state_d == ST_COLLECT) || (state_d == ST_FULL);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      en_q    <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fail_q  <= 1'b0;
      shift_q <= '0;
      cnt_q   <= '0;
      rep_q   <= '0;
      prev_q  <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fail_q  <= fail_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      rep_q   <= rep_d;
      prev_q  <= prev_d;
      wcnt_q  <= wcnt_d;
    end
  end

endmodule

// File: tb/tb_trng_collector.sv
// tb/tb_trng_collector.sv - directed self-checking bench for trng_collector
module tb_trng_collector;
  import trng_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable_i;
  logic       trng_in;
  logic       trng_en_o;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic       health_fail_o;
  logic       clear_fail_i;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int t0       = 0;

  logic [7:0] hs_data[$];
  int         hs_lat[$];

  localparam logic [15:0] STREAM_B2  = 16'h9A59;
  localparam logic [15:0] STREAM_4D  = 16'h65A6;
  localparam logic [23:0] STREAM_B2D = 24'h87A179;

  trng_collector #(
    .WORD_WIDTH    (8),
    .WARMUP_CYCLES (4),
    .REP_LIMIT     (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable_i      (enable_i),
    .trng_in       (trng_in),
    .trng_en_o     (trng_en_o),
    .data_o        (data_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .health_fail_o (health_fail_o),
    .clear_fail_i  (clear_fail_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every handshake (taken at the following rising edge) with its latency from start().
  always begin
    @(negedge clk);
    #2;
    if (valid_o && ready_i) begin
      hs_data.push_back(data_o);
      hs_lat.push_back(cyc - t0);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] hs_data_at(input int i);
    if (i < hs_data.size()) return 32'(hs_data[i]);
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] hs_lat_at(input int i);
    if (i < hs_lat.size()) return 32'(hs_lat[i]);
    return 32'hDEAD_BEEF;
  endfunction

  task automatic drive(input logic [127:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      trng_in = v[n-1-i];
      @(negedge clk);
    end
  endtask

  // Phase-aligned 11/00 pairs: discarded by the debiaser, runs stay short.
  task automatic filler(input int pairs);
    for (int p = 0; p < pairs; p++) begin
      trng_in = (p % 2 == 0);
      @(negedge clk);
      @(negedge clk);
    end
  endtask

  // Enable from IDLE; returns at the negedge whose sample becomes the first phase-0 sample.
  task automatic start();
    hs_data.delete();
    hs_lat.delete();
    t0       = cyc;
    enable_i = 1'b1;
    trng_in  = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic stop();
    enable_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst_n        = 1'b0;
    enable_i     = 1'b0;
    trng_in      = 1'b0;
    ready_i      = 1'b0;
    clear_fail_i = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_en",    32'(trng_en_o),     32'd0);
    check("rst_valid", 32'(valid_o),       32'd0);
    check("rst_fail",  32'(health_fail_o), 32'd0);
    check("rst_data",  32'(data_o),        32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Warm-up timing
    enable_i = 1'b1;
    @(negedge clk);
    check("wu_en", 32'(trng_en_o), 32'd1);
    repeat (3) @(negedge clk);
    check("wu_still_warmup", 32'(dut.state_q), 32'(ST_WARMUP));
    @(negedge clk);
    check("wu_collect", 32'(dut.state_q), 32'(ST_COLLECT));
    enable_i = 1'b0;
    @(negedge clk);
    check("wu_off_en",   32'(trng_en_o),   32'd0);
    check("wu_off_idle", 32'(dut.state_q), 32'(ST_IDLE));
    @(negedge clk);

    // Basic packing, ready held high
    ready_i = 1'b1;
    start();
    drive(128'(STREAM_B2), 16);
    filler(4);
    check("pack_count", 32'(hs_data.size()), 32'd1);
    check("pack_data",  hs_data_at(0), 32'hB2);
    check("pack_lat",   hs_lat_at(0),  32'd21);
    check("pack_valid_drop", 32'(valid_o), 32'd0);
    stop();

    // Same word with four discarded pairs interleaved
    start();
    drive(128'(STREAM_B2D), 24);
    filler(4);
    check("disc_count", 32'(hs_data.size()), 32'd1);
    check("disc_data",  hs_data_at(0), 32'hB2);
    check("disc_lat",   hs_lat_at(0),  32'd29);
    stop();

    // Backpressure: second word parks in FULL
    ready_i = 1'b0;
    start();
    drive(128'(STREAM_B2), 16);
    drive(128'(STREAM_4D), 16);
    check("bp_valid1", 32'(valid_o), 32'd1);
    check("bp_data1",  32'(data_o),  32'hB2);
    filler(2);
    check("bp_full",   32'(dut.state_q), 32'(ST_FULL));
    check("bp_valid2", 32'(valid_o), 32'd1);
    check("bp_data2",  32'(data_o),  32'hB2);
    ready_i = 1'b1;
    @(negedge clk);
    check("bp_valid3", 32'(valid_o), 32'd1);
    check("bp_data3",  32'(data_o),  32'h4D);
    filler(3);
    check("bp_count",  32'(hs_data.size()), 32'd2);
    check("bp_hs0",    hs_data_at(0), 32'hB2);
    check("bp_hs1",    hs_data_at(1), 32'h4D);
    check("bp_valid_drop", 32'(valid_o), 32'd0);
    stop();

    // Health failure: constant 1 trips the repetition test
    start();
    drive(128'h3FF, 10);
    check("hf_fail",  32'(health_fail_o), 32'd1);
    check("hf_en",    32'(trng_en_o),     32'd0);
    check("hf_valid", 32'(valid_o),       32'd0);
    enable_i = 1'b0;
    @(negedge clk);
    enable_i = 1'b1;
    repeat (2) @(negedge clk);
    check("hf_sticky",    32'(health_fail_o), 32'd1);
    check("hf_en_ignore", 32'(trng_en_o),     32'd0);
    enable_i     = 1'b0;
    clear_fail_i = 1'b1;
    @(negedge clk);
    clear_fail_i = 1'b0;
    check("hf_cleared", 32'(health_fail_o), 32'd0);
    check("hf_idle",    32'(dut.state_q),   32'(ST_IDLE));
    @(negedge clk);

    // Abort after five debiased bits, then a fresh word
    start();
    drive(128'h196, 10);
    enable_i = 1'b0;
    @(negedge clk);
    check("ab_en",    32'(trng_en_o), 32'd0);
    check("ab_valid", 32'(valid_o),   32'd0);
    check("ab_hold",  32'(data_o),    32'h4D);
    @(negedge clk);
    start();
    drive(128'(STREAM_B2), 16);
    filler(4);
    check("ab_count", 32'(hs_data.size()), 32'd1);
    check("ab_data",  hs_data_at(0), 32'hB2);
    check("ab_lat",   hs_lat_at(0),  32'd21);
    stop();

    // Asynchronous reset mid-word, then a fresh word
    start();
    drive(128'h196, 10);
    rst_n    = 1'b0;
    enable_i = 1'b0;
    #1;
    check("ar_en",    32'(trng_en_o),     32'd0);
    check("ar_valid", 32'(valid_o),       32'd0);
    check("ar_data",  32'(data_o),        32'd0);
    check("ar_fail",  32'(health_fail_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start();
    drive(128'(STREAM_B2), 16);
    filler(4);
    check("ar_count", 32'(hs_data.size()), 32'd1);
    check("ar_data2", hs_data_at(0), 32'hB2);
    check("ar_lat",   hs_lat_at(0),  32'd21);
    stop();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
